// File: rtl/indications_pkg.sv
// Shared types and colour constants for the life/status overlay.
package indications_pkg;

  typedef enum logic [1:0] {IDLE, LOSS, GAIN, DEAD} ind_state_t;

  localparam logic [7:0] ICON_BODY   = 8'hE0;
  localparam logic [7:0] ICON_BORDER = 8'h80;
  localparam logic [7:0] FLASH       = 8'hFC;
  localparam logic [7:0] DEAD_HI     = 8'hE0;
  localparam logic [7:0] DEAD_LO     = 8'h60;
  localparam logic [7:0] TRANSPARENT = 8'h00;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icon_row_locator.sv
// Maps a pixel onto the icon row: row span, icon hit/index and border ring.
module icon_row_locator
  import indications_pkg::*;
#(
  parameter int unsigned MAX_LIFE  = 8,
  parameter int unsigned ICON_SIZE = 16,
  parameter int unsigned ICON_GAP  = 4,
  parameter int unsigned ORIGIN_X  = 16,
  parameter int unsigned ORIGIN_Y  = 16,
  localparam int unsigned IDX_W    = idx_width(MAX_LIFE)
) (
  input  logic [10:0]      pixel_x,
  input  logic [10:0]      pixel_y,
  output logic             in_row,
  output logic             in_icon,
  output logic [IDX_W-1:0] icon_idx,
  output logic             on_border
);

  localparam int unsigned PITCH = ICON_SIZE + ICON_GAP;
  localparam logic [10:0] X_START = 11'(ORIGIN_X);
  localparam logic [10:0] X_END   = 11'(ORIGIN_X + MAX_LIFE * ICON_SIZE + (MAX_LIFE - 1) * ICON_GAP);
  localparam logic [10:0] Y_TOP   = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_BOT   = 11'(ORIGIN_Y + ICON_SIZE);
  localparam logic [10:0] SIZE    = 11'(ICON_SIZE);

  logic        y_hit;
  logic [10:0] x0;

  always_comb begin
    y_hit     = (pixel_y >= Y_TOP) && (pixel_y < Y_BOT);
    in_row    = y_hit && (pixel_x >= X_START) && (pixel_x < X_END);
    in_icon   = 1'b0;
    icon_idx  = '0;
    on_border = 1'b0;
    x0        = '0;
    // Icons never overlap, so at most one iteration can hit.
    for (int unsigned i = 0; i < MAX_LIFE; i++) begin
      x0 = 11'(ORIGIN_X + i * PITCH);
      if (y_hit && (pixel_x >= x0) && (pixel_x < x0 + SIZE)) begin
        in_icon   = 1'b1;
        icon_idx  = IDX_W'(i);
        on_border = (pixel_x == x0) || (pixel_x == x0 + SIZE - 11'd1) ||
                    (pixel_y == Y_TOP) || (pixel_y == Y_BOT - 11'd1);
      end
    end
  end

endmodule

// File: rtl/life_indicator_animated.sv
// Life icon overlay with loss blink, gain flash and game-over bar; life sampled per frame.
module life_indicator_animated
  import indications_pkg::*;
#(
  parameter int unsigned MAX_LIFE    = 8,
  parameter int unsigned LIFE_W      = 4,
  parameter int unsigned ICON_SIZE   = 16,
  parameter int unsigned ICON_GAP    = 4,
  parameter int unsigned ORIGIN_X    = 16,
  parameter int unsigned ORIGIN_Y    = 16,
  parameter int unsigned ANIM_FRAMES = 60,
  parameter int unsigned BLINK_HALF  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOfFrame,
  input  logic [10:0]       pixelX,
  input  logic [10:0]       pixelY,
  input  logic [LIFE_W-1:0] life,
  output logic              drawIndications,
  output logic [7:0]        RGBIndications,
  output logic              gameOver
);

  localparam int unsigned IDX_W     = idx_width(MAX_LIFE);
  localparam int unsigned SHOWN_W   = $clog2(MAX_LIFE + 1);
  localparam int unsigned CNT_MAX   = (ANIM_FRAMES > 2 * BLINK_HALF) ? ANIM_FRAMES : 2 * BLINK_HALF;
  localparam int unsigned CNT_W     = idx_width(CNT_MAX);
  localparam int unsigned ROW_RIGHT = ORIGIN_X + MAX_LIFE * ICON_SIZE + (MAX_LIFE - 1) * ICON_GAP;
  localparam bit          ROW_FITS  = (ROW_RIGHT <= SCREEN_W) && (ORIGIN_Y + ICON_SIZE <= SCREEN_H);

  ind_state_t         state;
  logic [SHOWN_W-1:0] shown;
  logic [SHOWN_W-1:0] lost_idx;
  logic [SHOWN_W-1:0] life_c;
  logic [CNT_W-1:0]   frame_cnt;
  logic               primed;
  logic               blink_on;
  logic               in_row;
  logic               in_icon;
  logic               on_border;
  logic [IDX_W-1:0]   icon_idx;
  logic               draw_next;
  logic [7:0]         rgb_next;

  icon_row_locator #(
    .MAX_LIFE (MAX_LIFE),
    .ICON_SIZE(ICON_SIZE),
    .ICON_GAP (ICON_GAP),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y)
  ) u_locator (
    .pixel_x  (pixelX),
    .pixel_y  (pixelY),
    .in_row   (in_row),
    .in_icon  (in_icon),
    .icon_idx (icon_idx),
    .on_border(on_border)
  );

  always_comb begin
    life_c = (32'(life) > MAX_LIFE) ? SHOWN_W'(MAX_LIFE) : SHOWN_W'(life);
  end

  assign blink_on = ((32'(frame_cnt) / BLINK_HALF) % 2) == 0;
  assign gameOver = (state == DEAD);

  always_comb begin
    draw_next = 1'b0;
    rgb_next  = TRANSPARENT;
    if (state == DEAD) begin
      if (in_row) begin
        draw_next = 1'b1;
        rgb_next  = blink_on ? DEAD_HI : DEAD_LO;
      end
    end else if (in_icon) begin
      if (32'(icon_idx) < 32'(shown)) begin
        draw_next = 1'b1;
        rgb_next  = on_border ? ICON_BORDER :
                    ((state == GAIN) && blink_on) ? FLASH : ICON_BODY;
      end else if ((state == LOSS) && (32'(icon_idx) == 32'(lost_idx)) && blink_on) begin
        draw_next = 1'b1;
        rgb_next  = on_border ? ICON_BORDER : ICON_BODY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      shown           <= '0;
      lost_idx        <= '0;
      frame_cnt       <= '0;
      primed          <= 1'b0;
      drawIndications <= 1'b0;
      RGBIndications  <= TRANSPARENT;
    end else begin
      drawIndications <= draw_next;
      RGBIndications  <= rgb_next;
      if (startOfFrame) begin
        shown  <= life_c;
        primed <= 1'b1;
        if (life_c == '0) begin
          if (state != DEAD) begin
            state     <= DEAD;
            frame_cnt <= '0;
          end else begin
            frame_cnt <= (32'(frame_cnt) >= 2 * BLINK_HALF - 1) ? '0 : frame_cnt + CNT_W'(1);
          end
        end else if (!primed) begin
          // First sample after reset just loads the count; power-up is not a gain.
          state <= IDLE;
        end else if (state == DEAD) begin
          state     <= GAIN;
          frame_cnt <= '0;
        end else if (life_c < shown) begin
          state     <= LOSS;
          lost_idx  <= life_c;
          frame_cnt <= '0;
        end else if (life_c > shown) begin
          state     <= GAIN;
          frame_cnt <= '0;
        end else if ((state == LOSS) || (state == GAIN)) begin
          if (32'(frame_cnt) >= ANIM_FRAMES - 1) state <= IDLE;
          else frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    assert (ROW_FITS) else $error("icon row does not fit inside 640x480");
  end

endmodule

// File: tb/tb_life_indicator_animated.sv
// Directed self-checking bench for life_indicator_animated with default geometry.
module tb_life_indicator_animated;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [3:0]  life;
  logic        drawIndications;
  logic [7:0]  RGBIndications;
  logic        gameOver;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  life_indicator_animated #(
    .MAX_LIFE   (8),
    .LIFE_W     (4),
    .ICON_SIZE  (16),
    .ICON_GAP   (4),
    .ORIGIN_X   (16),
    .ORIGIN_Y   (16),
    .ANIM_FRAMES(60),
    .BLINK_HALF (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .life           (life),
    .drawIndications(drawIndications),
    .RGBIndications (RGBIndications),
    .gameOver       (gameOver)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame(input logic [3:0] l);
    life         = l;
    pixelX       = '0;
    pixelY       = '0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic d, input logic [7:0] c);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
    check({tag, " draw"}, 32'(drawIndications), 32'(d));
    check({tag, " rgb"}, 32'(RGBIndications), 32'(c));
  endtask

  initial begin
    logic on;
    reset = 1'b1; startOfFrame = 1'b0; life = '0; pixelX = '0; pixelY = '0;
    tick(); tick();
    check("reset draw", 32'(drawIndications), 32'd0);
    check("reset rgb", 32'(RGBIndications), 32'h00);
    check("reset gameOver", 32'(gameOver), 32'd0);
    reset = 1'b0;

    // 1: power-up with three lives
    new_frame(4'd3);
    probe("t1 icon0 corner", 16, 16, 1'b1, 8'h80);
    probe("t1 icon0 body", 20, 20, 1'b1, 8'hE0);
    pixelX = '0; pixelY = '0; #1;
    check("t1 latency hold", 32'(drawIndications), 32'd1);
    probe("t1 icon2 body", 60, 20, 1'b1, 8'hE0);
    probe("t1 icon3 off", 76, 20, 1'b0, 8'h00);
    probe("t1 gap", 33, 20, 1'b0, 8'h00);
    probe("t1 above row", 20, 15, 1'b0, 8'h00);

    // 2: loss 3->2, icon 2 blinks for 60 frames
    new_frame(4'd2);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) new_frame(4'd2);
      on = ((k / 8) % 2) == 0;
      probe($sformatf("t2 f%0d lost", k), 60, 20, on, on ? 8'hE0 : 8'h00);
      if (k == 0) probe("t2 lost border", 56, 16, 1'b1, 8'h80);
    end
    new_frame(4'd2);
    probe("t2 idle lost", 60, 20, 1'b0, 8'h00);
    probe("t2 idle icon1", 40, 20, 1'b1, 8'hE0);
    check("t2 gameOver", 32'(gameOver), 32'd0);

    // 3: 3 -> 1 -> 0
    new_frame(4'd3);
    new_frame(4'd1);
    probe("t3 icon0", 20, 20, 1'b1, 8'hE0);
    probe("t3 lost icon1", 40, 20, 1'b1, 8'hE0);
    probe("t3 icon2 off", 60, 20, 1'b0, 8'h00);
    check("t3 loss gameOver", 32'(gameOver), 32'd0);
    new_frame(4'd0);
    check("t3 dead gameOver", 32'(gameOver), 32'd1);
    probe("t3 bar gap", 33, 20, 1'b1, 8'hE0);
    probe("t3 bar right end", 171, 31, 1'b1, 8'hE0);
    probe("t3 past bar", 172, 20, 1'b0, 8'h00);
    probe("t3 below bar", 100, 32, 1'b0, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      new_frame(4'd0);
      probe($sformatf("t3 f%0d bar", k), 100, 20, 1'b1, ((k % 16) / 8 == 0) ? 8'hE0 : 8'h60);
    end

    // 4: new game from DEAD with five lives
    new_frame(4'd5);
    check("t4 gameOver", 32'(gameOver), 32'd0);
    for (int k = 0; k < 60; k++) begin
      if (k > 0) new_frame(4'd5);
      on = ((k / 8) % 2) == 0;
      probe($sformatf("t4 f%0d body", k), 100, 20, 1'b1, on ? 8'hFC : 8'hE0);
      if (k % 20 == 0) begin
        probe($sformatf("t4 f%0d border", k), 96, 16, 1'b1, 8'h80);
        probe($sformatf("t4 f%0d icon5", k), 120, 20, 1'b0, 8'h00);
      end
    end
    new_frame(4'd5);
    probe("t4 idle body", 100, 20, 1'b1, 8'hE0);

    // 5: clamp to eight icons, mid-frame life changes ignored
    new_frame(4'd12);
    probe("t5 icon7", 160, 20, 1'b1, 8'hFC);
    probe("t5 icon8 off", 180, 20, 1'b0, 8'h00);
    life = 4'd0;
    probe("t5 midframe icon7", 160, 20, 1'b1, 8'hFC);
    check("t5 midframe gameOver", 32'(gameOver), 32'd0);
    life = 4'd3;
    probe("t5 midframe icon1", 40, 20, 1'b1, 8'hFC);
    new_frame(4'd8);
    probe("t5 same count", 160, 20, 1'b1, 8'hFC);
    new_frame(4'd15);
    probe("t5 clamp again", 160, 20, 1'b1, 8'hFC);

    // 6: reset in the middle of a loss animation
    new_frame(4'd7);
    probe("t6 lost icon7", 160, 20, 1'b1, 8'hE0);
    probe("t6 icon6", 140, 20, 1'b1, 8'hE0);
    reset = 1'b1; pixelX = 11'd160; pixelY = 11'd20;
    tick();
    check("t6 reset draw", 32'(drawIndications), 32'd0);
    check("t6 reset rgb", 32'(RGBIndications), 32'h00);
    check("t6 reset gameOver", 32'(gameOver), 32'd0);
    reset = 1'b0;
    probe("t6 after reset", 160, 20, 1'b0, 8'h00);
    new_frame(4'd3);
    probe("t6 recover icon2", 60, 20, 1'b1, 8'hE0);
    probe("t6 recover icon7", 160, 20, 1'b0, 8'h00);

    // startOfFrame on a row pixel: new state visible one clock later
    pixelX = 11'd33; pixelY = 11'd20; life = 4'd0; startOfFrame = 1'b1;
    tick();
    check("edge old state", 32'(drawIndications), 32'd0);
    startOfFrame = 1'b0;
    tick();
    check("edge new draw", 32'(drawIndications), 32'd1);
    check("edge new rgb", 32'(RGBIndications), 32'hE0);
    check("edge gameOver", 32'(gameOver), 32'd1);

    // zero life straight out of reset goes DEAD, then a gain flashes
    reset = 1'b1; tick(); reset = 1'b0;
    new_frame(4'd0);
    check("reset-dead gameOver", 32'(gameOver), 32'd1);
    new_frame(4'd4);
    check("reset-dead gain gameOver", 32'(gameOver), 32'd0);
    probe("reset-dead gain icon3", 80, 20, 1'b1, 8'hFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
